// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the ALU issue/writeback stage: instruction op
//   codes (ALU encoding 0-12 plus the stage-level ops 13-15), the issue FSM
//   state type, and the register index type.
package alu_issue_pkg;

  typedef logic [1:0] reg_idx_t;
  typedef logic [3:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_NOT   = 4'd5;
  localparam op_t OP_NEG   = 4'd6;
  localparam op_t OP_PASSA = 4'd7;
  localparam op_t OP_PASSB = 4'd8;
  localparam op_t OP_SHL1  = 4'd9;
  localparam op_t OP_SHR1  = 4'd10;
  localparam op_t OP_INC   = 4'd11;
  localparam op_t OP_DEC   = 4'd12;
  localparam op_t OP_SHLN  = 4'd13;
  localparam op_t OP_SHRN  = 4'd14;
  localparam op_t OP_CLR   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2
  } state_t;

  function automatic logic is_shift_n(op_t op);
    return (op == OP_SHLN) || (op == OP_SHRN);
  endfunction

  // ALU op presented for an accepted instruction. Multi-step shifts are
  // turned into their shift-by-one ALU op; a zero count degenerates to a
  // plain pass of operand A so it can share the single-cycle path.
  function automatic op_t issue_alu_op(op_t op, logic [2:0] k);
    op_t res;
    res = op;
    if (is_shift_n(op)) begin
      if (k == 3'd0)          res = OP_PASSA;
      else if (op == OP_SHLN) res = OP_SHL1;
      else                    res = OP_SHR1;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREG x 8-bit register file with two combinational read ports and one
//   synchronous write port; synchronous active-high reset clears all entries.
// Ports:
//   clk_i, rst_i       clock / synchronous reset
//   ra_a_i, rd_a_o     read port A address / data
//   ra_b_i, rd_b_o     read port B address / data
//   we_i, wa_i, wd_i   write enable / address / data
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  reg_idx_t   ra_a_i,
  output logic [7:0] rd_a_o,
  input  reg_idx_t   ra_b_i,
  output logic [7:0] rd_b_o,
  input  logic       we_i,
  input  reg_idx_t   wa_i,
  input  logic [7:0] wd_i
);

  logic [7:0] r_mem [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= 8'h00;
    end else if (we_i) begin
      r_mem[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = r_mem[ra_a_i];
  assign rd_b_o = r_mem[ra_b_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Issue/writeback stage in front of an 8-bit combinational ALU. Accepts
//   two-address instructions (rd = dest and operand A, rs/imm = operand B),
//   registers the ALU inputs, writes the ALU result back with zero/neg flags,
//   and iterates shift-by-one ALU ops for multi-step shifts (ops 13/14).
//
//   state | meaning
//   IDLE  | nothing in flight
//   EXEC  | single-cycle op in flight, writes back on the next edge
//   ITER  | multi-step shift in flight, cnt steps remaining
//
// Ports:
//   clk_i, rst_i                 clock / synchronous active-high reset
//   in_valid_i, in_ready_o       instruction handshake
//   in_op_i, in_rd_i, in_rs_i    op code, destination/A register, B register
//   in_imm_sel_i, in_imm_i       immediate select and value (shift count [2:0])
//   alu_a_o, alu_b_o, alu_op_o   registered ALU inputs
//   alu_r_i                      combinational ALU result
//   wb_valid_o, wb_reg_o, wb_data_o  writeback pulse, register and value
//   zero_o, neg_o                flags of the last written value
//   busy_o                       an instruction is in flight
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [3:0] in_op_i,
  input  logic [1:0] in_rd_i,
  input  logic [1:0] in_rs_i,
  input  logic       in_imm_sel_i,
  input  logic [7:0] in_imm_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [3:0] alu_op_o,
  input  logic [7:0] alu_r_i,
  output logic       wb_valid_o,
  output logic [1:0] wb_reg_o,
  output logic [7:0] wb_data_o,
  output logic       zero_o,
  output logic       neg_o,
  output logic       busy_o
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  reg_idx_t   r_dst;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  op_t        r_alu_op;
  logic       r_wb_valid;
  reg_idx_t   r_wb_reg;
  logic [7:0] r_wb_data;
  logic       r_zero;
  logic       r_neg;

  logic       w_ready;
  logic       w_busy;
  logic       w_wb_en;
  logic       w_accept;
  logic [2:0] w_k;
  logic       w_go_iter;
  logic       w_fwd;
  logic [7:0] w_rf_a;
  logic [7:0] w_rf_b;
  logic [7:0] w_opa;
  logic [7:0] w_opb;
  op_t        w_alu_op_nxt;

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ra_a_i (in_rd_i),
    .rd_a_o (w_rf_a),
    .ra_b_i (in_rs_i),
    .rd_b_o (w_rf_b),
    .we_i   (w_wb_en),
    .wa_i   (r_dst),
    .wd_i   (alu_r_i)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_go_iter ? ITER : EXEC;
      end
      EXEC: begin
        if (w_accept) w_state_nxt = w_go_iter ? ITER : EXEC;
        else          w_state_nxt = IDLE;
      end
      ITER: begin
        if (r_cnt <= 3'd1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b0;
    w_wb_en = 1'b0;
    case (r_state)
      EXEC: begin
        w_busy  = 1'b1;
        w_wb_en = 1'b1;
      end
      ITER: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
        w_wb_en = (r_cnt == 3'd1);
      end
      default: ;
    endcase
  end

  assign in_ready_o = w_ready;
  assign busy_o     = w_busy;
  assign w_accept   = in_valid_i && w_ready;

  // ---------------- operand selection ----------------
  assign w_k          = in_imm_i[2:0];
  assign w_go_iter    = is_shift_n(in_op_i) && (w_k != 3'd0);
  assign w_alu_op_nxt = issue_alu_op(in_op_i, w_k);

  // While EXEC is in flight the register file still holds the old value of
  // r_dst (it is written on this same edge), so bypass the ALU result.
  assign w_fwd = (r_state == EXEC);
  assign w_opa = (w_fwd && (in_rd_i == r_dst)) ? alu_r_i : w_rf_a;
  assign w_opb = in_imm_sel_i                  ? in_imm_i :
                 (w_fwd && (in_rs_i == r_dst)) ? alu_r_i  : w_rf_b;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alu_a    <= 8'h00;
      r_alu_b    <= 8'h00;
      r_alu_op   <= OP_ADD;
      r_dst      <= 2'd0;
      r_cnt      <= 3'd0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= 2'd0;
      r_wb_data  <= 8'h00;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_en;
      if (w_wb_en) begin
        r_wb_reg  <= r_dst;
        r_wb_data <= alu_r_i;
        r_zero    <= (alu_r_i == 8'h00);
        r_neg     <= alu_r_i[7];
      end

      if (w_accept) begin
        r_alu_a  <= w_opa;
        r_alu_b  <= w_opb;
        r_alu_op <= w_alu_op_nxt;
        r_dst    <= in_rd_i;
        r_cnt    <= w_go_iter ? w_k : 3'd0;
      end else if ((r_state == ITER) && (r_cnt > 3'd1)) begin
        // feed the partial shift back as the next operand A
        r_alu_a <= alu_r_i;
        r_cnt   <= r_cnt - 3'd1;
      end
    end
  end

  assign alu_a_o    = r_alu_a;
  assign alu_b_o    = r_alu_b;
  assign alu_op_o   = r_alu_op;
  assign wb_valid_o = r_wb_valid;
  assign wb_reg_o   = r_wb_reg;
  assign wb_data_o  = r_wb_data;
  assign zero_o     = r_zero;
  assign neg_o      = r_neg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Directed bench for alu_issue. Provides the external combinational ALU,
//   keeps an instruction-level reference model (architectural registers plus
//   a queue of expected writebacks with their due cycles), compares the DUT
//   against it every cycle, and pins the model with literal expectations.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [3:0] in_op_i = 4'd0;
  logic [1:0] in_rd_i = 2'd0;
  logic [1:0] in_rs_i = 2'd0;
  logic       in_imm_sel_i = 1'b0;
  logic [7:0] in_imm_i = 8'h00;
  logic [7:0] alu_a_o, alu_b_o;
  logic [3:0] alu_op_o;
  logic [7:0] alu_r;
  logic       wb_valid_o;
  logic [1:0] wb_reg_o;
  logic [7:0] wb_data_o;
  logic       zero_o, neg_o, busy_o;

  always #5 clk = ~clk;

  alu_issue #(.NREG(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_op_i      (in_op_i),
    .in_rd_i      (in_rd_i),
    .in_rs_i      (in_rs_i),
    .in_imm_sel_i (in_imm_sel_i),
    .in_imm_i     (in_imm_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_r_i      (alu_r),
    .wb_valid_o   (wb_valid_o),
    .wb_reg_o     (wb_reg_o),
    .wb_data_o    (wb_data_o),
    .zero_o       (zero_o),
    .neg_o        (neg_o),
    .busy_o       (busy_o)
  );

  // External 8-bit ALU
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return 8'h00 - a;
      4'd7:  return a;
      4'd8:  return b;
      4'd9:  return {a[6:0], 1'b0};
      4'd10: return {1'b0, a[7:1]};
      4'd11: return a + 8'd1;
      4'd12: return a - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_r = alu_fn(alu_op_o, alu_a_o, alu_b_o);

  // Architectural result of one instruction
  function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] imm);
    case (op)
      4'd13:   return a << imm[2:0];
      4'd14:   return a >> imm[2:0];
      4'd15:   return 8'h00;
      default: return alu_fn(op, a, b);
    endcase
  endfunction

  typedef struct {
    int         acc;
    int         wbc;
    logic [1:0] rg;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mregs [4];
  logic       m_zero = 1'b0;
  logic       m_neg  = 1'b0;
  int         it_lo = 1;
  int         it_hi = 0;
  int         cyc = 0;
  logic [7:0] wb_log[$];
  int         n_vec = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic ev;
    logic eb;
    if (!rst_i) begin
      ev = (q.size() > 0) && (q[0].wbc == cyc);
      chk("wb_valid", 32'(wb_valid_o), 32'(ev));
      if (wb_valid_o) wb_log.push_back(wb_data_o);
      if (ev) begin
        chk("wb_reg", 32'(wb_reg_o), 32'(q[0].rg));
        chk("wb_data", 32'(wb_data_o), 32'(q[0].d));
        m_zero = (q[0].d == 8'h00);
        m_neg  = q[0].d[7];
        void'(q.pop_front());
      end
      chk("zero", 32'(zero_o), 32'(m_zero));
      chk("neg", 32'(neg_o), 32'(m_neg));
      chk("in_ready", 32'(in_ready_o), 32'(!(cyc >= it_lo && cyc <= it_hi)));
      eb = 1'b0;
      foreach (q[i]) if (q[i].acc <= cyc && cyc < q[i].wbc) eb = 1'b1;
      chk("busy", 32'(busy_o), 32'(eb));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic isel, input logic [7:0] imm);
    logic [7:0] a, b, res;
    int c;
    exp_t e;
    @(negedge clk);
    while (cyc >= it_lo && cyc <= it_hi) @(negedge clk);
    c = cyc;
    #1;
    in_valid_i   = 1'b1;
    in_op_i      = op;
    in_rd_i      = rd;
    in_rs_i      = rs;
    in_imm_sel_i = isel;
    in_imm_i     = imm;
    a   = mregs[rd];
    b   = isel ? imm : mregs[rs];
    res = ref_result(op, a, b, imm);
    mregs[rd] = res;
    e.acc = c + 1;
    e.rg  = rd;
    e.d   = res;
    if ((op == 4'd13 || op == 4'd14) && imm[2:0] != 3'd0) begin
      e.wbc = c + 1 + int'(imm[2:0]);
      it_lo = c + 1;
      it_hi = c + int'(imm[2:0]);
    end else begin
      e.wbc = c + 2;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    #1 in_valid_i = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // One reset cycle; model cleared, then reset values pinned with literals
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    m_zero = 1'b0;
    m_neg  = 1'b0;
    it_lo  = 1;
    it_hi  = 0;
    @(negedge clk);
    chk("rst_alu_a", 32'(alu_a_o), 32'h00);
    chk("rst_alu_b", 32'(alu_b_o), 32'h00);
    chk("rst_alu_op", 32'(alu_op_o), 32'h0);
    chk("rst_wb_data", 32'(wb_data_o), 32'h00);
    chk("rst_wb_reg", 32'(wb_reg_o), 32'h0);
    chk("rst_ready", 32'(in_ready_o), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int low;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    repeat (3) @(posedge clk);
    do_reset();

    // immediate loads then add, back to back
    wb_log.delete();
    issue(4'd8, 2'd0, 2'd0, 1'b1, 8'h05);
    issue(4'd8, 2'd1, 2'd0, 1'b1, 8'h07);
    issue(4'd0, 2'd0, 2'd1, 1'b0, 8'h00);
    idle(3);
    chk("t1_n", 32'(wb_log.size()), 32'd3);
    if (wb_log.size() == 3) begin
      chk("t1_wb0", 32'(wb_log[0]), 32'h05);
      chk("t1_wb1", 32'(wb_log[1]), 32'h07);
      chk("t1_wb2", 32'(wb_log[2]), 32'h0C);
    end
    chk("t1_zero", 32'(zero_o), 32'h0);

    // dependent increment chain through forwarding
    wb_log.delete();
    issue(4'd8, 2'd0, 2'd0, 1'b1, 8'h01);
    repeat (3) issue(4'd11, 2'd0, 2'd0, 1'b0, 8'h00);
    idle(3);
    chk("t2_n", 32'(wb_log.size()), 32'd4);
    if (wb_log.size() == 4) begin
      chk("t2_wb1", 32'(wb_log[1]), 32'h02);
      chk("t2_wb2", 32'(wb_log[2]), 32'h03);
      chk("t2_wb3", 32'(wb_log[3]), 32'h04);
    end

    // multi-step shift left by 3
    wb_log.delete();
    issue(4'd8, 2'd2, 2'd0, 1'b1, 8'h03);
    issue(4'd13, 2'd2, 2'd0, 1'b1, 8'h03);
    low = 0;
    repeat (6) begin
      @(negedge clk);
      if (!in_ready_o) begin
        low++;
        chk("t3_alu_op", 32'(alu_op_o), 32'd9);
      end
      #1 in_valid_i = 1'b0;
    end
    chk("t3_low_cycles", 32'(low), 32'd3);
    chk("t3_n", 32'(wb_log.size()), 32'd2);
    if (wb_log.size() == 2) chk("t3_wb", 32'(wb_log[1]), 32'h18);

    // shift edge cases: k=0 and k=7
    wb_log.delete();
    issue(4'd8, 2'd2, 2'd0, 1'b1, 8'h81);
    issue(4'd13, 2'd2, 2'd0, 1'b1, 8'h00);
    idle(3);
    chk("t4_neg", 32'(neg_o), 32'h1);
    issue(4'd8, 2'd3, 2'd0, 1'b1, 8'h80);
    issue(4'd14, 2'd3, 2'd0, 1'b1, 8'h07);
    idle(10);
    chk("t4_n", 32'(wb_log.size()), 32'd4);
    if (wb_log.size() == 4) begin
      chk("t4_k0", 32'(wb_log[1]), 32'h81);
      chk("t4_k7", 32'(wb_log[3]), 32'h01);
    end

    // flags, clear, decrement wrap, and
    wb_log.delete();
    issue(4'd8, 2'd0, 2'd0, 1'b1, 8'h10);
    issue(4'd8, 2'd1, 2'd0, 1'b1, 8'h10);
    issue(4'd1, 2'd0, 2'd1, 1'b0, 8'h00);
    idle(3);
    chk("t5_zero", 32'(zero_o), 32'h1);
    issue(4'd8, 2'd3, 2'd0, 1'b1, 8'h5A);
    issue(4'd15, 2'd3, 2'd0, 1'b0, 8'h00);
    issue(4'd12, 2'd3, 2'd0, 1'b0, 8'h00);
    issue(4'd2, 2'd3, 2'd1, 1'b0, 8'h00);
    idle(3);
    chk("t5_n", 32'(wb_log.size()), 32'd7);
    if (wb_log.size() == 7) begin
      chk("t5_sub", 32'(wb_log[2]), 32'h00);
      chk("t5_clr", 32'(wb_log[4]), 32'h00);
      chk("t5_dec", 32'(wb_log[5]), 32'hFF);
      chk("t5_and", 32'(wb_log[6]), 32'h10);
    end

    // reset during the second iteration of a k=5 shift
    issue(4'd8, 2'd1, 2'd0, 1'b1, 8'h22);
    issue(4'd8, 2'd0, 2'd0, 1'b1, 8'h11);
    issue(4'd14, 2'd0, 2'd0, 1'b1, 8'h05);
    @(negedge clk);
    #1 in_valid_i = 1'b0;
    do_reset();
    wb_log.delete();
    for (int r = 0; r < 4; r++) issue(4'd7, 2'(r), 2'd0, 1'b0, 8'h00);
    idle(8);
    chk("t6_n", 32'(wb_log.size()), 32'd4);
    foreach (wb_log[i]) chk("t6_reg_zero", 32'(wb_log[i]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
